// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache between the CPU data port and the SDRAM arbiter.
// Latency: read hit is combinational; a read miss costs request wait plus a 4-beat burst; a write costs one capture cycle plus the request wait.
// Backpressure: d_cache_miss stalls the CPU while busy; mem_req is held with a stable address until mem_ready.
module d_cache_ctrl #(
    parameter int IDX_W  = 5,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_inv,
    output logic [7:0]        cpu_rdata,
    output logic              d_cache_miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam int TAG_W = ADDR_W - IDX_W - 3;
    localparam int LINES = 1 << IDX_W;
    localparam int BYTES = LINES * 8;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_DATA, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [ADDR_W-4:0]      line_q, line_d;       // {tag, idx} of the line being refilled
    logic [ADDR_W-1:0]      buf_addr_q, buf_addr_d;
    logic [7:0]             buf_data_q, buf_data_d;
    logic [1:0]             beat_q, beat_d;
    logic                   pend_q, pend_d;

    // Tag and data storage carry no reset; validity alone decides a hit.
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [7:0]             data_q [BYTES];

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag_in;
    logic                   hit;
    logic                   rd_miss;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   wr_hit_we;
    logic                   fill_we;
    logic                   tag_we;
    logic                   clear_all;

    assign idx      = cpu_addr[IDX_W+2:3];
    assign tag_in   = cpu_addr[ADDR_W-1:IDX_W+3];
    assign hit      = valid_q[idx] & (tag_q[idx] == tag_in);
    assign rd_miss  = cpu_rd & ~cpu_wr & ~hit;
    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[ADDR_W-4:IDX_W];

    assign cpu_rdata = data_q[{idx, cpu_addr[2:0]}];

    // Next-state, stall and memory-request decode.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        line_d       = line_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        beat_d       = beat_q;
        wr_hit_we    = 1'b0;
        fill_we      = 1'b0;
        tag_we       = 1'b0;
        clear_all    = 1'b0;
        d_cache_miss = (state_q != IDLE);
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 2'b00;

        case (state_q)
            IDLE: begin
                d_cache_miss = rd_miss;
                if (cpu_wr) begin
                    // Write-through: capture now, patch the line only if it is resident.
                    buf_addr_d = cpu_addr;
                    buf_data_d = cpu_wdata;
                    wr_hit_we  = hit;
                    state_d    = WRITE;
                end else if (rd_miss) begin
                    line_d       = {tag_in, idx};
                    valid_d[idx] = 1'b0;
                    beat_d       = 2'd0;
                    state_d      = FILL_REQ;
                end else if (pend_q | (cpu_inv & ~cpu_rd)) begin
                    clear_all = 1'b1;
                    valid_d   = '0;
                end
            end
            FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {line_q, 2'b00};
                if (mem_ready) begin
                    state_d = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        tag_we            = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        state_d           = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = buf_addr_q[ADDR_W-1:1];
                mem_wdata = {buf_data_q, buf_data_q};
                mem_be    = buf_addr_q[0] ? 2'b10 : 2'b01;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An invalidate that cannot be honoured this cycle is remembered until a free IDLE cycle.
        if (clear_all) begin
            pend_d = cpu_inv & cpu_rd;
        end else begin
            pend_d = pend_q | cpu_inv;
        end
    end

    // Control state; reset aborts any burst or write in flight.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            line_q     <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            beat_q     <= 2'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            line_q     <= line_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
        end
    end

    // Data and tag arrays: byte patch on write hit, two bytes per refill beat, tag on the last beat.
    always_ff @(posedge clk) begin
        if (wr_hit_we) begin
            data_q[{idx, cpu_addr[2:0]}] <= cpu_wdata;
        end
        if (fill_we) begin
            data_q[{fill_idx, beat_q, 1'b0}] <= mem_rdata[7:0];
            data_q[{fill_idx, beat_q, 1'b1}] <= mem_rdata[15:8];
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl: a per-cycle vector table for the main read/write flow,
// then hand-written sequences for stalls, invalidate during refill and reset mid-refill.
module tb_d_cache_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr, cpu_inv;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        d_cache_miss;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    d_cache_ctrl dut (
        .clk(clk), .RST(RST),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_inv(cpu_inv), .cpu_rdata(cpu_rdata), .d_cache_miss(d_cache_miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rdy, rvld;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [15:0] rdat;
        logic        e_miss, e_req, e_we;
        logic [14:0] e_maddr;
        logic [15:0] e_wdata;
        logic [1:0]  e_be;
        logic        chk_rd;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [7:0] wd, input logic rdy, input logic rvld,
                                input logic [15:0] rdat, input logic em, input logic er,
                                input logic ewe, input logic [14:0] ema, input logic [15:0] ewd,
                                input logic [1:0] ebe, input logic crd, input logic [7:0] erd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.rdy = rdy; v.rvld = rvld;
        v.rdat = rdat; v.e_miss = em; v.e_req = er; v.e_we = ewe; v.e_maddr = ema;
        v.e_wdata = ewd; v.e_be = ebe; v.chk_rd = crd; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic inv, input logic [15:0] addr,
                         input logic [7:0] wd, input logic rdy, input logic rvld, input logic [15:0] rdat);
        cpu_rd = rd; cpu_wr = wr; cpu_inv = inv; cpu_addr = addr; cpu_wdata = wd;
        mem_ready = rdy; mem_rvalid = rvld; mem_rdata = rdat;
    endtask

    task automatic chk_bus(input string tag, input logic em, input logic er, input logic ewe,
                           input logic [14:0] ema, input logic [15:0] ewd, input logic [1:0] ebe);
        chk({tag, " miss"},  {15'd0, d_cache_miss}, {15'd0, em});
        chk({tag, " req"},   {15'd0, mem_req},      {15'd0, er});
        chk({tag, " we"},    {15'd0, mem_we},       {15'd0, ewe});
        chk({tag, " maddr"}, {1'b0, mem_addr},      {1'b0, ema});
        chk({tag, " wdata"}, mem_wdata,             ewd);
        chk({tag, " be"},    {14'd0, mem_be},       {14'd0, ebe});
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk_bus("reset", 0, 0, 0, 15'h0000, 16'h0000, 2'b00);
        RST = 1'b0;
        #1;

        //           rd wr addr      wd    rdy rv rdat      miss req we maddr     wdata     be     crd rdata
        tbl[0]  = mk(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[1]  = mk(1, 0, 16'h1234, 8'h00, 1, 0, 16'h0000, 1, 1, 0, 15'h0918, 16'h0000, 2'b00, 0, 8'h00);
        tbl[2]  = mk(1, 0, 16'h1234, 8'h00, 0, 1, 16'h2211, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[3]  = mk(1, 0, 16'h1234, 8'h00, 0, 1, 16'h4433, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[4]  = mk(1, 0, 16'h1234, 8'h00, 0, 1, 16'h6655, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[5]  = mk(1, 0, 16'h1234, 8'h00, 0, 1, 16'h8877, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[6]  = mk(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 15'h0000, 16'h0000, 2'b00, 1, 8'h55);
        tbl[7]  = mk(1, 0, 16'h1237, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 15'h0000, 16'h0000, 2'b00, 1, 8'h88);
        tbl[8]  = mk(0, 1, 16'h1235, 8'hAB, 0, 0, 16'h0000, 0, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[9]  = mk(0, 0, 16'h1235, 8'h00, 0, 0, 16'h0000, 1, 1, 1, 15'h091A, 16'hABAB, 2'b10, 0, 8'h00);
        tbl[10] = mk(0, 0, 16'h1235, 8'h00, 1, 0, 16'h0000, 1, 1, 1, 15'h091A, 16'hABAB, 2'b10, 0, 8'h00);
        tbl[11] = mk(1, 0, 16'h1235, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 15'h0000, 16'h0000, 2'b00, 1, 8'hAB);
        tbl[12] = mk(0, 1, 16'h5000, 8'h5A, 0, 0, 16'h0000, 0, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);
        tbl[13] = mk(0, 0, 16'h5000, 8'h00, 1, 0, 16'h0000, 1, 1, 1, 15'h2800, 16'h5A5A, 2'b01, 0, 8'h00);
        tbl[14] = mk(1, 0, 16'h5000, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 15'h0000, 16'h0000, 2'b00, 0, 8'h00);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rd, tbl[i].wr, 0, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].rvld, tbl[i].rdat);
            #1;
            chk_bus($sformatf("row%0d", i), tbl[i].e_miss, tbl[i].e_req, tbl[i].e_we,
                    tbl[i].e_maddr, tbl[i].e_wdata, tbl[i].e_be);
            if (tbl[i].chk_rd) chk($sformatf("row%0d rdata", i), {8'd0, cpu_rdata}, {8'd0, tbl[i].e_rdata});
            tick();
        end

        // Refill of 0x5000 stalled 10 cycles; stray rvalid before acceptance must be ignored.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 16'h5000, 8'h00, 0, 1, 16'hFFFF);
            #1;
            chk_bus($sformatf("fillstall%0d", i), 1, 1, 0, 15'h2800, 16'h0000, 2'b00);
            tick();
        end
        drive(1, 0, 0, 16'h5000, 8'h00, 1, 0, 16'h0000);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 16'h5000, 8'h00, 0, 1, {8'(2*k+2), 8'(2*k+1)});
            tick();
        end
        drive(1, 0, 0, 16'h5000, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("rd5000 miss", {15'd0, d_cache_miss}, 16'd0);
        chk("rd5000 data", {8'd0, cpu_rdata}, 16'h0001);
        cpu_addr = 16'h5007;
        #1;
        chk("rd5007 data", {8'd0, cpu_rdata}, 16'h0008);
        cpu_addr = 16'h1234;
        #1;
        chk("rd1234 kept", {8'd0, cpu_rdata}, 16'h0055);
        tick();

        // Write to cached 0x1236 with the arbiter holding off for 10 cycles.
        drive(0, 1, 0, 16'h1236, 8'h3C, 0, 0, 16'h0000);
        #1;
        chk("wr1236 capture miss", {15'd0, d_cache_miss}, 16'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 16'h1236, 8'h00, 0, 0, 16'h0000);
            #1;
            chk_bus($sformatf("wrstall%0d", i), 1, 1, 1, 15'h091B, 16'h3C3C, 2'b01);
            tick();
        end
        drive(0, 0, 0, 16'h1236, 8'h00, 1, 0, 16'h0000);
        tick();
        drive(1, 0, 0, 16'h1236, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("rd1236 miss", {15'd0, d_cache_miss}, 16'd0);
        chk("rd1236 data", {8'd0, cpu_rdata}, 16'h003C);
        tick();

        // Invalidate pulse in a free IDLE cycle drops every line.
        drive(0, 0, 1, 16'h1234, 8'h00, 0, 0, 16'h0000);
        tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("inv idle rd miss", {15'd0, d_cache_miss}, 16'd1);
        tick();

        // Invalidate arriving during the refill is deferred until the refill completes.
        drive(1, 0, 0, 16'h1234, 8'h00, 1, 0, 16'h0000);
        tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h2211); tick();
        drive(1, 0, 1, 16'h1234, 8'h00, 0, 1, 16'h4433); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h6655); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h8877); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("inv fill done miss", {15'd0, d_cache_miss}, 16'd0);
        chk("inv fill done data", {8'd0, cpu_rdata}, 16'h0055);
        tick();
        #1;
        chk("inv deferred rd miss", {15'd0, d_cache_miss}, 16'd1);
        tick();

        // Reset after beat 1 of a refill aborts it at once.
        drive(1, 0, 0, 16'h1234, 8'h00, 1, 0, 16'h0000);
        #1;
        chk_bus("refill req", 1, 1, 0, 15'h0918, 16'h0000, 2'b00);
        tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h2211); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h4433); tick();
        drive(0, 0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000);
        RST = 1'b1;
        #1;
        chk_bus("rst midfill", 0, 0, 0, 15'h0000, 16'h0000, 2'b00);
        tick();
        RST = 1'b0;
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("post rst rd miss", {15'd0, d_cache_miss}, 16'd1);
        chk("post rst no req", {15'd0, mem_req}, 16'd0);
        tick();
        chk_bus("restart req", 1, 1, 0, 15'h0918, 16'h0000, 2'b00);
        drive(1, 0, 0, 16'h1234, 8'h00, 1, 0, 16'h0000);
        tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h1001); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h3002); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h5003); tick();
        drive(1, 0, 0, 16'h1234, 8'h00, 0, 1, 16'h7004); tick();
        drive(1, 0, 0, 16'h1233, 8'h00, 0, 0, 16'h0000);
        #1;
        chk("restart fill miss", {15'd0, d_cache_miss}, 16'd0);
        chk("restart fill byte3", {8'd0, cpu_rdata}, 16'h0030);
        tick();
        drive(0, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
